// File: rtl/gpio_byte_streamer.sv
// gpio_byte_streamer: snoops CPU stores on the data-memory bus, captures byte writes that land
// in the GPIO address window into a small FIFO, and drains each entry to off-chip pins over a
// 4-phase strobe/ack handshake. CPU stores never stall; hits on a full FIFO are dropped.
// Optional feature macro: GPIO_DROP_CNT_EN adds drop_clr/drop_cnt to count dropped hits.
module gpio_byte_streamer #(
    parameter logic [31:0] BASE_ADDR = 32'd153636,
    parameter int unsigned WIN_SIZE  = 256,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned OFF_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [31:0]            addr,
    input  logic [31:0]            wd,
    input  logic                   gpio_ack,
`ifdef GPIO_DROP_CNT_EN
    input  logic                   drop_clr,
    output logic [15:0]            drop_cnt,
`endif
    output logic [7:0]             gpio_data,
    output logic [OFF_W-1:0]       gpio_off,
    output logic                   gpio_stb,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    // One past the last window byte, computed in 33 bits so it cannot wrap.
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(WIN_SIZE);

    typedef enum logic [1:0] {
        StIdle,
        StStrobe,
        StRelease
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [7:0]       r_data_mem [DEPTH];
    logic [OFF_W-1:0] r_off_mem  [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;
    logic [LVL_W-1:0] w_level_next;
    logic             r_ack_meta;
    logic             r_ack_s;
    logic [7:0]       r_gpio_data;
    logic [OFF_W-1:0] r_gpio_off;
    logic [31:0]      w_diff;
    logic             w_hit;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_unused;

    assign w_diff  = addr - BASE_ADDR;
    assign w_hit   = we && (addr >= BASE_ADDR) && ({1'b0, addr} < WIN_END);
    // Full/empty come from the registered level only, so a hit on a full FIFO is dropped even
    // when a pop happens on the same edge.
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = w_hit && !w_full;
    assign w_pop   = (r_state == StIdle) && !w_empty;

    // Only the low data byte and low offset bits are captured.
    assign w_unused = ^{wd[31:8], w_diff[31:OFF_W]};

    // Next occupancy: +1 on push, -1 on pop, unchanged on both or neither.
    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LVL_W'(1);
            2'b01:   w_level_next = r_level - LVL_W'(1);
            default: w_level_next = r_level;
        endcase
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_level <= w_level_next;
        end
    end

    // FIFO storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wptr] <= wd[7:0];
            r_off_mem[r_wptr]  <= w_diff[OFF_W-1:0];
        end
    end

    // Two-flop synchronizer for the asynchronous acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= gpio_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    // Handshake FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    // Handshake FSM next state; IDLE never looks at ack, so a late ack cannot skip a byte.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:    if (!w_empty) w_state_next = StStrobe;
            StStrobe:  if (r_ack_s)  w_state_next = StRelease;
            StRelease: if (!r_ack_s) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Handshake FSM outputs; strobe follows the state so reset drops it immediately.
    always_comb begin
        gpio_stb = (r_state == StStrobe);
    end

    // Pin data/offset registers, loaded only on the IDLE->STROBE pop and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpio_data <= '0;
            r_gpio_off  <= '0;
        end else if (w_pop) begin
            r_gpio_data <= r_data_mem[r_rptr];
            r_gpio_off  <= r_off_mem[r_rptr];
        end
    end

    assign gpio_data  = r_gpio_data;
    assign gpio_off   = r_gpio_off;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign level      = r_level;

`ifdef GPIO_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = w_hit && w_full;

    // Saturating count of hits dropped on a full FIFO; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (drop_clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_gpio_byte_streamer.sv
// Bench for gpio_byte_streamer: queue-based reference model of the window/FIFO/handshake rules,
// a monitor that scores every strobed byte, and directed plus random store traffic.
module tb_gpio_byte_streamer;

    localparam logic [31:0] BASE  = 32'd153636;
    localparam int          WIN   = 256;
    localparam int          DEPTH = 8;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        we       = 1'b0;
    logic [31:0] addr     = '0;
    logic [31:0] wd       = '0;
    logic        man_ack  = 1'b0;
    logic        a_ack    = 1'b0;
    logic        auto_ack = 1'b0;
    logic        gpio_ack;
    logic [7:0]  gpio_data;
    logic [7:0]  gpio_off;
    logic        gpio_stb;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  level;
`ifdef GPIO_DROP_CNT_EN
    logic        drop_clr = 1'b0;
    logic [15:0] drop_cnt;
`endif

    assign gpio_ack = auto_ack ? a_ack : man_ack;

    gpio_byte_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .addr       (addr),
        .wd         (wd),
        .gpio_ack   (gpio_ack),
`ifdef GPIO_DROP_CNT_EN
        .drop_clr   (drop_clr),
        .drop_cnt   (drop_cnt),
`endif
        .gpio_data  (gpio_data),
        .gpio_off   (gpio_off),
        .gpio_stb   (gpio_stb),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .level      (level)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    logic [15:0] exp_q[$];
    int          occ       = 0;
    bit          pend_push = 1'b0;
    bit          in_reset  = 1'b1;
    int          exp_drops = 0;
    logic [15:0] cur       = '0;
    bit          prev_stb  = 1'b0;
    int          ack_low   = 100;
    int          n_stb     = 0;
    int          ad_phase  = 0;
    int          ad_cnt    = 0;

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Scoreboard monitor: on each strobe rising edge pop the oldest expected byte.
    always begin
        @(posedge clk);
        #1;
        if (in_reset) begin
            prev_stb  = 1'b0;
            pend_push = 1'b0;
            ack_low   = 100;
        end else begin
            if (pend_push) begin
                occ++;
                pend_push = 1'b0;
            end
            ack_low = gpio_ack ? 0 : ack_low + 1;
            if (gpio_stb && !prev_stb) begin
                n_stb++;
                // Ack must be seen low through both sync flops before a new strobe.
                chk("stb_after_ack_low", 32'(ack_low >= 4), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(n_stb), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    occ--;
                    chk("strobe_data", 32'(gpio_data), 32'(cur[7:0]));
                    chk("strobe_off", 32'(gpio_off), 32'(cur[15:8]));
                end
            end else if (gpio_stb) begin
                chk("hold_data", 32'(gpio_data), 32'(cur[7:0]));
                chk("hold_off", 32'(gpio_off), 32'(cur[15:8]));
            end
            prev_stb = gpio_stb;
        end
    end

    // Occupancy flags against the model, sampled mid-cycle.
    always begin
        @(negedge clk);
        if (!in_reset) begin
            chk("level", 32'(level), 32'(occ));
            chk("fifo_empty", 32'(fifo_empty), 32'(occ == 0));
            chk("fifo_full", 32'(fifo_full), 32'(occ == DEPTH));
        end
    end

    // Random-delay external responder used when auto_ack is set.
    always begin
        @(negedge clk);
        if (rst || !auto_ack) begin
            ad_phase = 0;
            ad_cnt   = 0;
            a_ack    = 1'b0;
        end else begin
            case (ad_phase)
                0: if (gpio_stb) begin
                    ad_cnt   = $urandom_range(0, 20);
                    ad_phase = 1;
                end
                1: if (ad_cnt == 0) begin
                    a_ack    = 1'b1;
                    ad_phase = 2;
                end else ad_cnt--;
                2: if (!gpio_stb) begin
                    ad_cnt   = $urandom_range(0, 20);
                    ad_phase = 3;
                end
                default: if (ad_cnt == 0) begin
                    a_ack    = 1'b0;
                    ad_phase = 0;
                end else ad_cnt--;
            endcase
        end
    end

    // One store on the bus for one cycle; the expectation is decided from the model occupancy.
    task automatic store(input logic [31:0] a, input logic [31:0] w);
        logic [31:0] off;
        @(negedge clk);
        we   = 1'b1;
        addr = a;
        wd   = w;
        if ((a >= BASE) && (a < BASE + WIN)) begin
            if (occ < DEPTH) begin
                off = a - BASE;
                exp_q.push_back({off[7:0], w[7:0]});
                pend_push = 1'b1;
            end else if (exp_drops < 65535) begin
                exp_drops++;
            end
        end
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wait_stb(input logic v, input int budget, input string name);
        int n = 0;
        while (gpio_stb !== v && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(gpio_stb), 32'(v));
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !gpio_stb && !gpio_ack && ad_phase == 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({name, "_q"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_empty"}, 32'(fifo_empty), 32'd1);
        chk({name, "_stb"}, 32'(gpio_stb), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          s0;

        // Reset state.
        #12;
        chk("rst_stb", 32'(gpio_stb), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_data", 32'(gpio_data), 32'd0);
        chk("rst_off", 32'(gpio_off), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_reset = 1'b0;

        // Single byte with manual handshake.
        store(BASE + 5, 32'h1234_56A7);
        chk("t2_stb_edge1", 32'(gpio_stb), 32'd0);
        @(posedge clk);
        #1;
        chk("t2_stb_edge2", 32'(gpio_stb), 32'd1);
        chk("t2_data", 32'(gpio_data), 32'hA7);
        chk("t2_off", 32'(gpio_off), 32'd5);
        @(negedge clk);
        man_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t2_stb_ack_sync", 32'(gpio_stb), 32'd1);
        @(posedge clk);
        #1;
        chk("t2_stb_released", 32'(gpio_stb), 32'd0);
        @(negedge clk);
        man_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t2_idle_empty", 32'(fifo_empty), 32'd1);
        chk("t2_idle_stb", 32'(gpio_stb), 32'd0);

        // Asynchronous reset while strobing with bytes queued.
        store(BASE + 1, 32'h11);
        store(BASE + 2, 32'h22);
        store(BASE + 3, 32'h33);
        wait_stb(1'b1, 10, "t1_stb_up");
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_reset = 1'b1;
        #1;
        chk("t1_async_stb", 32'(gpio_stb), 32'd0);
        chk("t1_async_empty", 32'(fifo_empty), 32'd1);
        chk("t1_async_level", 32'(level), 32'd0);
        exp_q.delete();
        occ       = 0;
        pend_push = 1'b0;
        exp_drops = 0;
        @(negedge clk);
        rst      = 1'b0;
        in_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_no_replay", 32'(gpio_stb), 32'd0);

        // Window edges: only the first and last window bytes stream.
        auto_ack = 1'b1;
        s0 = n_stb;
        store(32'd153635, 32'h11);
        store(32'd153636, 32'h22);
        store(32'd153891, 32'h33);
        store(32'd153892, 32'h44);
        wait_drain(400, "t3_drain");
        chk("t3_strobes", 32'(n_stb - s0), 32'd2);

        // Overflow with ack held low: one byte on pins, eight queued, tenth dropped.
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        for (int i = 0; i < 10; i++) store(BASE + 32'(i * 7), 32'(i));
        chk("t4_full", 32'(fifo_full), 32'd1);
        chk("t4_stb", 32'(gpio_stb), 32'd1);
        chk("t4_head", 32'(gpio_data), 32'h00);
`ifdef GPIO_DROP_CNT_EN
        chk("t4_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
        @(negedge clk);
        drop_clr = 1'b1;
        @(negedge clk);
        drop_clr  = 1'b0;
        exp_drops = 0;
        chk("t4_drop_clr", 32'(drop_cnt), 32'd0);
`endif
        auto_ack = 1'b1;
        wait_drain(2000, "t4_drain");

        // Push and pop on the same edge at level 3.
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        for (int i = 0; i < 4; i++) store(BASE + 32'(40 + i), 32'(8'hC0 + i));
        chk("t5_level_pre", 32'(level), 32'd3);
        @(negedge clk);
        man_ack = 1'b1;
        wait_stb(1'b0, 20, "t5_release");
        @(negedge clk);
        man_ack = 1'b0;
        repeat (2) @(negedge clk);
        store(BASE + 77, 32'h5A);
        chk("t5_restrobe", 32'(gpio_stb), 32'd1);
        chk("t5_level_same", 32'(level), 32'd3);
        auto_ack = 1'b1;
        wait_drain(2000, "t5_drain");

        // Random traffic with random ack delays.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASE + 32'($urandom_range(0, WIN - 1));
            else if (r == 7) a = BASE - 32'($urandom_range(1, 1000));
            else if (r == 8) a = BASE + 32'(WIN) + 32'($urandom_range(0, 1000));
            else             a = $urandom;
            store(a, $urandom);
        end
        wait_drain(20000, "t6_drain");
`ifdef GPIO_DROP_CNT_EN
        chk("t6_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
